bist_scheduler: RTL

Sequencer that runs a batch of BIST tests on the `bist` engine without host intervention. It sits between the JTAG-side configuration registers and one `bist` instance. For each selected test it drives `BIST_CONF_REG` and `ENABLE` to the engine, waits for a completion code and records the outcome. Results are summarised as pass/fail masks plus a snapshot of the first failure.

---
 rtl/bist_scheduler.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bist_scheduler.sv
// Batch sequencer for the bist engine: walks the selected tests in index order,
// drives the engine, and summarises outcomes as pass/fail masks plus a first-failure snapshot.
module bist_scheduler #(
    parameter int TIMEOUT = 300,
    parameter int SETTLE  = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        ABORT,
    input  logic [16:0] TEST_MASK,
    input  logic [7:0]  TEST_LEN,
    input  logic        STOP_ON_FAIL,
    input  logic [15:0] BIST_STATUS_REG,
    output logic        BIST_ENABLE,
    output logic [12:0] BIST_CONF_REG,
    output logic        BUSY,
    output logic        DONE,
    output logic [16:0] PASS_MASK,
    output logic [16:0] FAIL_MASK,
    output logic        TIMEOUT_FLAG,
    output logic [4:0]  FIRST_FAIL_NUM,
    output logic [15:0] FIRST_FAIL_STATUS,
    output logic [2:0]  state_dbg
);
    // Handshake: START is a level request honoured only while idle; BUSY covers the
    // batch; DONE pulses for one cycle at its end; ABORT ends any active batch next edge.

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
    localparam logic [CW-1:0] LAST_C   = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_CONFIG, S_RUN, S_GAP, S_FINISH
    } state_t;

    state_t        state, next_state;
    logic [16:0]   mask_q;
    logic [7:0]    len_q;
    logic          sof_q;
    logic [4:0]    cursor;
    logic          cursor_vld;
    logic [CW-1:0] cnt;
    logic [16:0]   above;
    logic [4:0]    sel;
    logic          found;
    logic          run_pass, run_fail, run_tmo;

    assign state_dbg = state;

    // cursor_vld low stands for "cursor at -1": every selected test is still ahead.
    always_comb begin
        above = cursor_vld ? (mask_q & ({17{1'b1}} << (cursor + 5'd1))) : mask_q;
        sel   = 5'd0;
        for (int i = 16; i >= 0; i--) begin
            if (above[i]) sel = 5'(i);
        end
    end

    assign found = |above;

    always_comb begin
        next_state = state;
        run_pass   = 1'b0;
        run_fail   = 1'b0;
        run_tmo    = 1'b0;
        case (state)
            S_IDLE:   if (START) next_state = (TEST_MASK == '0) ? S_FINISH : S_SELECT;
            S_SELECT: next_state = found ? S_CONFIG : S_FINISH;
            S_CONFIG: next_state = S_RUN;
            S_RUN: begin
                if (cnt >= SETTLE_C && BIST_STATUS_REG[3:0] == 4'hF)      run_pass = 1'b1;
                else if (cnt >= SETTLE_C && BIST_STATUS_REG[3:0] == 4'h5) run_fail = 1'b1;
                else if (cnt == LAST_C)                                   run_tmo  = 1'b1;
                if (run_pass || run_fail || run_tmo) next_state = S_GAP;
            end
            S_GAP:    next_state = (sof_q && FAIL_MASK != '0) ? S_FINISH : S_SELECT;
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        // Abort wins over any completion code seen in the same cycle.
        if (ABORT && state != S_IDLE && state != S_FINISH) begin
            next_state = S_FINISH;
            run_pass   = 1'b0;
            run_fail   = 1'b0;
            run_tmo    = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state             <= S_IDLE;
            mask_q            <= '0;
            len_q             <= '0;
            sof_q             <= 1'b0;
            cursor            <= '0;
            cursor_vld        <= 1'b0;
            cnt               <= '0;
            BIST_ENABLE       <= 1'b0;
            BIST_CONF_REG     <= '0;
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
            PASS_MASK         <= '0;
            FAIL_MASK         <= '0;
            TIMEOUT_FLAG      <= 1'b0;
            FIRST_FAIL_NUM    <= '0;
            FIRST_FAIL_STATUS <= '0;
        end else begin
            state       <= next_state;
            BUSY        <= (next_state != S_IDLE) && (next_state != S_FINISH);
            DONE        <= (next_state == S_FINISH);
            BIST_ENABLE <= (next_state == S_RUN);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        mask_q            <= TEST_MASK;
                        len_q             <= TEST_LEN;
                        sof_q             <= STOP_ON_FAIL;
                        cursor_vld        <= 1'b0;
                        PASS_MASK         <= '0;
                        FAIL_MASK         <= '0;
                        TIMEOUT_FLAG      <= 1'b0;
                        FIRST_FAIL_NUM    <= '0;
                        FIRST_FAIL_STATUS <= '0;
                    end
                end
                S_SELECT: begin
                    if (next_state == S_CONFIG) begin
                        cursor        <= sel;
                        cursor_vld    <= 1'b1;
                        BIST_CONF_REG <= {sel == 5'd16, sel[3:0], len_q};
                        cnt           <= '0;
                    end
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (run_pass) PASS_MASK[cursor] <= 1'b1;
                    if (run_tmo)  TIMEOUT_FLAG      <= 1'b1;
                    if (run_fail || run_tmo) begin
                        FAIL_MASK[cursor] <= 1'b1;
                        if (FAIL_MASK == '0) begin
                            FIRST_FAIL_NUM    <= cursor;
                            FIRST_FAIL_STATUS <= run_tmo ? 16'h000E : BIST_STATUS_REG;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
